// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch sequencer: FSM states, trap causes, instruction size.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_TIMEOUT    = 2'd2
    } trap_cause_t;

    localparam int INSTR_BYTES = 4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next sequential/redirect PC with target alignment check.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the selection is used.
module pc_next_mux
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_current,
    input  logic        halt_req,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] seq_pc,
    output logic        target_misaligned,
    output logic        enter_halt
);

    logic [31:0] pc_plus;

    assign pc_plus = pc_current + 32'(INSTR_BYTES);

    // A halting instruction still retires normally, so it advances like a plain one.
    always_comb begin
        seq_pc            = pc_plus;
        target_misaligned = 1'b0;
        enter_halt        = 1'b0;
        if (halt_req) begin
            enter_halt = 1'b1;
        end else if (jump) begin
            seq_pc            = jump_target;
            target_misaligned = is_misaligned(jump_target);
        end else if (branch_taken) begin
            seq_pc            = branch_target;
            target_misaligned = is_misaligned(branch_target);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: boot, fetch handshake, redirects, halt/resume and trap entry.
// pc_next is combinational (0 cycles); trap_pc/trap_cause register on trap entry.
// Stalls by holding pc_next = pc_current while imem_ready is low, until timeout.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_current,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_commit,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic        trap_valid,
    output logic [31:0] trap_pc,
    output logic [1:0]  trap_cause
);

    // Counter holds the number of already-elapsed wait cycles, so the trap fires
    // on the FETCH_TIMEOUT-th consecutive cycle without imem_ready.
    localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

    seq_state_t  state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [31:0] trap_pc_nxt;
    trap_cause_t cause_q, cause_nxt;

    logic [31:0] seq_pc;
    logic        target_misaligned;
    logic        enter_halt;
    logic        timeout_hit;

    pc_next_mux u_mux (
        .pc_current        (pc_current),
        .halt_req          (halt_req),
        .jump              (jump),
        .jump_target       (jump_target),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .seq_pc            (seq_pc),
        .target_misaligned (target_misaligned),
        .enter_halt        (enter_halt)
    );

    assign imem_addr   = pc_current;
    assign trap_cause  = cause_q;
    assign timeout_hit = (FETCH_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        trap_pc_nxt  = trap_pc;
        cause_nxt    = cause_q;
        pc_next      = reset ? RESET_VECTOR : pc_current;
        imem_req     = 1'b0;
        instr_commit = 1'b0;
        halted       = 1'b0;
        trap_valid   = 1'b0;

        if (!reset) begin
            case (state)
                BOOT: begin
                    pc_next   = RESET_VECTOR;
                    state_nxt = FETCH;
                end
                FETCH: begin
                    imem_req = 1'b1;
                    if (!imem_ready) begin
                        if (timeout_hit) begin
                            pc_next     = TRAP_VECTOR;
                            trap_pc_nxt = pc_current;
                            cause_nxt   = CAUSE_TIMEOUT;
                            state_nxt   = TRAP;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 16'd1;
                        end
                    end else begin
                        instr_commit = 1'b1;
                        if (target_misaligned) begin
                            pc_next     = TRAP_VECTOR;
                            trap_pc_nxt = pc_current;
                            cause_nxt   = CAUSE_MISALIGNED;
                            state_nxt   = TRAP;
                        end else begin
                            pc_next = seq_pc;
                            if (enter_halt) begin
                                state_nxt = HALT;
                            end
                        end
                    end
                end
                TRAP: begin
                    trap_valid = 1'b1;
                    state_nxt  = FETCH;
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            wait_cnt <= '0;
            trap_pc  <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            trap_pc  <= trap_pc_nxt;
            cause_q  <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer with a cycle-level reference model
// and a queue-based scoreboard checked by an independent monitor.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          TO = 16;

    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_TRAP  = 2;
    localparam int M_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_current = 32'h0;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        instr_commit;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [1:0]  trap_cause;

    always #5 clk = ~clk;

    always @(posedge clk) pc_current <= pc_next;

    pc_sequencer #(
        .RESET_VECTOR  (RV),
        .TRAP_VECTOR   (TV),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_current    (pc_current),
        .pc_next       (pc_next),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .instr_commit  (instr_commit),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .halted        (halted),
        .trap_valid    (trap_valid),
        .trap_pc       (trap_pc),
        .trap_cause    (trap_cause)
    );

    typedef struct {
        logic [31:0] pc_cur;
        logic [31:0] pc_nxt;
        logic        req;
        logic        commit;
        logic        hlt;
        logic        tv;
        logic [31:0] tpc;
        logic [1:0]  tcause;
        bit          regs_known;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the core is doing, in plain terms.
    int          m_mode   = M_BOOT;
    logic [31:0] m_pc     = 32'h0;
    logic [31:0] m_tpc    = 32'h0;
    logic [1:0]  m_tcause = 2'd0;
    int          m_wait   = 0;
    bit          first    = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the expected response is queued for the monitor.
    task automatic step(input bit rst, input bit rdy, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt, input bit hr, input bit rs);
        exp_t        e;
        logic [31:0] nx;
        logic [31:0] tgt;
        logic [31:0] ntpc;
        logic [1:0]  ncause;
        int          nmode;
        @(posedge clk);
        #1;
        reset = rst; imem_ready = rdy; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt; halt_req = hr; resume = rs;

        e.pc_cur = m_pc; e.req = 1'b0; e.commit = 1'b0; e.hlt = 1'b0; e.tv = 1'b0;
        e.tpc = m_tpc; e.tcause = m_tcause; e.regs_known = !first;
        first  = 1'b0;
        nx     = m_pc;
        nmode  = m_mode;
        ntpc   = m_tpc;
        ncause = m_tcause;
        if (rst) begin
            nx = RV; nmode = M_BOOT; m_wait = 0; ntpc = 32'h0; ncause = 2'd0;
        end else if (m_mode == M_BOOT) begin
            nx = RV; nmode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            e.req = 1'b1;
            if (!rdy) begin
                m_wait++;
                if (TO != 0 && m_wait >= TO) begin
                    nx = TV; nmode = M_TRAP; ntpc = m_pc; ncause = 2'd2; m_wait = 0;
                end
            end else begin
                e.commit = 1'b1;
                m_wait   = 0;
                if (hr) begin
                    nx = m_pc + 32'd4; nmode = M_HALT;
                end else if (jp || br) begin
                    tgt = jp ? jt : bt;
                    if (tgt % 4 != 0) begin
                        nx = TV; nmode = M_TRAP; ntpc = m_pc; ncause = 2'd1;
                    end else begin
                        nx = tgt;
                    end
                end else begin
                    nx = m_pc + 32'd4;
                end
            end
        end else if (m_mode == M_TRAP) begin
            e.tv = 1'b1; nmode = M_FETCH;
        end else begin
            e.hlt = 1'b1; m_wait = 0;
            if (rs) nmode = M_FETCH;
        end
        e.pc_nxt = nx;
        sb.push_back(e);
        m_pc = nx; m_mode = nmode; m_tpc = ntpc; m_tcause = ncause;
    endtask

    task automatic go(input int n, input bit rdy);
        repeat (n) step(1'b0, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic jmp(input logic [31:0] t);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, t, 1'b0, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_current", pc_current, e.pc_cur);
                chk("pc_next", pc_next, e.pc_nxt);
                chk("imem_addr", imem_addr, e.pc_cur);
                chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
                chk("instr_commit", {31'h0, instr_commit}, {31'h0, e.commit});
                chk("halted", {31'h0, halted}, {31'h0, e.hlt});
                chk("trap_valid", {31'h0, trap_valid}, {31'h0, e.tv});
                if (e.regs_known) begin
                    chk("trap_pc", trap_pc, e.tpc);
                    chk("trap_cause", {30'h0, trap_cause}, {30'h0, e.tcause});
                end
            end
        end
    end

    initial begin
        int          stall_left;
        bit          rst, rdy, br, jp, hr, rs;
        logic [31:0] bt, jt;

        // Boot and linear fetch, with a 3-cycle wait at PC 8.
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        go(3, 1'b1);
        go(3, 1'b0);
        go(1, 1'b1);
        // Jump beats branch at PC 12.
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b0);
        jmp(32'h10);
        // Misaligned branch at 0x10, then trap cycle, then fetch at 0x100.
        step(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 1'b0);
        go(1, 1'b1);
        jmp(32'h20);
        // Fetch timeout at 0x20.
        go(16, 1'b0);
        go(1, 1'b0);
        jmp(32'h30);
        // Halt at 0x30; halt_req while halted must be ignored.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        go(2, 1'b1);
        // Jump misaligned with aligned branch, and the reverse.
        step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h203, 1'b0, 1'b0);
        go(1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'h201, 1'b1, 32'h300, 1'b0, 1'b0);
        // Reset in the middle of a wait.
        go(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        go(2, 1'b1);
        // PC wrap-around.
        jmp(32'hFFFF_FFF8);
        go(3, 1'b1);

        // Randomized traffic, including long stalls to reach the timeout.
        stall_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                if ($urandom_range(0, 99) == 0) stall_left = $urandom_range(10, 20);
                rdy = ($urandom_range(0, 4) != 0);
            end
            br = ($urandom_range(0, 4) == 0);
            jp = ($urandom_range(0, 7) == 0);
            hr = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 3) == 0);
            bt = $urandom & 32'hFFFF_FFFC;
            jt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) jt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) jt = 32'hFFFF_FFFC;
            step(rst, rdy, br, bt, jp, jt, hr, rs);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
